// File: rtl/instr_encoder_pkg.sv
// Shared RV32I definitions: opcodes, request kinds, error codes and FSM states.
package instr_encoder_pkg;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;

  typedef enum logic [2:0] {
    KIND_R   = 3'd0,
    KIND_I   = 3'd1,
    KIND_LW  = 3'd2,
    KIND_SW  = 3'd3,
    KIND_BEQ = 3'd4,
    KIND_JAL = 3'd5,
    KIND_LUI = 3'd6,
    KIND_ILL = 3'd7
  } kind_e;

  typedef enum logic [2:0] {
    ERR_NONE  = 3'd0,
    ERR_RANGE = 3'd1,
    ERR_ALIGN = 3'd2,
    ERR_FIELD = 3'd3
  } err_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ENC,
    ST_OUT
  } state_e;

  typedef struct packed {
    kind_e       kind;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  funct3;
    logic        alt;
    logic [31:0] imm;
  } req_t;

  // True when v is representable as a w-bit two's complement value.
  function automatic logic sext_ok(input logic [31:0] v, input int unsigned w);
    logic [31:0] m;
    m = '1 << (w - 1);
    return ((v & m) == '0) || ((v & m) == m);
  endfunction

endpackage

// File: rtl/instr_encoder_if.sv
// Request channel and instruction-memory write channel of the encoder.
interface instr_encoder_if;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_kind;
  logic [4:0]  in_rd;
  logic [4:0]  in_rs1;
  logic [4:0]  in_rs2;
  logic [2:0]  in_funct3;
  logic        in_alt;
  logic [31:0] in_imm;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_addr;
  logic [31:0] out_instr;

  modport master (
    output in_valid, in_kind, in_rd, in_rs1, in_rs2, in_funct3, in_alt, in_imm, out_ready,
    input  in_ready, out_valid, out_addr, out_instr
  );

  modport slave (
    input  in_valid, in_kind, in_rd, in_rs1, in_rs2, in_funct3, in_alt, in_imm, out_ready,
    output in_ready, out_valid, out_addr, out_instr
  );
endinterface

// File: rtl/instr_encoder_pack.sv
// Combinational RV32I packer: checks one request and builds its instruction word.
module instr_pack
  import instr_encoder_pkg::*;
(
  input  req_t        req_i,
  output logic [31:0] word_o,
  output logic        legal_o,
  output err_e        code_o
);

  logic [31:0] imm;
  assign imm = req_i.imm;

  // Range errors take precedence over alignment and field errors.
  always_comb begin
    word_o = '0;
    code_o = ERR_NONE;
    unique case (req_i.kind)
      KIND_R: begin
        word_o = {1'b0, req_i.alt, 5'b0, req_i.rs2, req_i.rs1, req_i.funct3, req_i.rd, OPC_OP};
        if (req_i.alt && (req_i.funct3 != 3'b000)) code_o = ERR_FIELD;
      end
      KIND_I: begin
        word_o = {imm[11:0], req_i.rs1, req_i.funct3, req_i.rd, OPC_OP_IMM};
        if (!sext_ok(imm, 12)) code_o = ERR_RANGE;
        else if ((req_i.funct3 == 3'b001) && (imm[11:5] != '0)) code_o = ERR_FIELD;
      end
      KIND_LW: begin
        word_o = {imm[11:0], req_i.rs1, 3'b010, req_i.rd, OPC_LOAD};
        if (!sext_ok(imm, 12)) code_o = ERR_RANGE;
      end
      KIND_SW: begin
        word_o = {imm[11:5], req_i.rs2, req_i.rs1, 3'b010, imm[4:0], OPC_STORE};
        if (!sext_ok(imm, 12)) code_o = ERR_RANGE;
      end
      KIND_BEQ: begin
        word_o = {imm[12], imm[10:5], req_i.rs2, req_i.rs1, 3'b000, imm[4:1], imm[11], OPC_BRANCH};
        if (!sext_ok(imm, 13)) code_o = ERR_RANGE;
        else if (imm[0]) code_o = ERR_ALIGN;
      end
      KIND_JAL: begin
        word_o = {imm[20], imm[10:1], imm[11], imm[19:12], req_i.rd, OPC_JAL};
        if (!sext_ok(imm, 21)) code_o = ERR_RANGE;
        else if (imm[0]) code_o = ERR_ALIGN;
      end
      KIND_LUI: begin
        word_o = {imm[31:12], req_i.rd, OPC_LUI};
        if (imm[11:0] != '0) code_o = ERR_FIELD;
      end
      default: code_o = ERR_FIELD;
    endcase
  end

  assign legal_o = (code_o == ERR_NONE);

endmodule

// File: rtl/instr_encoder.sv
// RV32I instruction encoder: accepts requests, packs them and writes words to
// sequential instruction-memory addresses, tracking count and first error.
module instr_encoder
  import instr_encoder_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] base_addr,
  instr_encoder_if.slave bus,
  output logic        err,
  output logic [2:0]  err_code,
  output logic [15:0] count
);

  state_e      state_q, state_d;
  req_t        req_q, req_d;
  logic        in_ready_q, in_ready_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] instr_q, instr_d;
  logic [15:0] count_q, count_d;
  logic        err_q, err_d;
  err_e        code_q, code_d;

  logic [31:0] pack_word;
  logic        pack_legal;
  err_e        pack_code;

  instr_pack u_pack (
    .req_i   (req_q),
    .word_o  (pack_word),
    .legal_o (pack_legal),
    .code_o  (pack_code)
  );

  // Next-state and datapath updates; start overrides everything else.
  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    addr_d  = addr_q;
    instr_d = instr_q;
    count_d = count_q;
    err_d   = err_q;
    code_d  = code_q;
    if (start) begin
      state_d = ST_IDLE;
      addr_d  = base_addr;
      count_d = '0;
      err_d   = 1'b0;
      code_d  = ERR_NONE;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (bus.in_valid && in_ready_q) begin
            state_d = ST_ENC;
            req_d   = '{kind:   kind_e'(bus.in_kind),
                        rd:     bus.in_rd,
                        rs1:    bus.in_rs1,
                        rs2:    bus.in_rs2,
                        funct3: bus.in_funct3,
                        alt:    bus.in_alt,
                        imm:    bus.in_imm};
          end
        end
        ST_ENC: begin
          if (pack_legal) begin
            state_d = ST_OUT;
            instr_d = pack_word;
          end else begin
            state_d = ST_IDLE;
            err_d   = 1'b1;
            if (!err_q) code_d = pack_code;
          end
        end
        ST_OUT: begin
          if (bus.out_ready) begin
            state_d = ST_IDLE;
            addr_d  = addr_q + 32'd4;
            if (count_q != '1) count_d = count_q + 16'd1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
    // in_ready is registered so it reads 0 throughout reset and rises on the first edge after.
    in_ready_d = (state_d == ST_IDLE);
  end

  // State, output and captured-request registers with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      req_q      <= '0;
      in_ready_q <= 1'b0;
      addr_q     <= '0;
      instr_q    <= '0;
      count_q    <= '0;
      err_q      <= 1'b0;
      code_q     <= ERR_NONE;
    end else begin
      state_q    <= state_d;
      req_q      <= req_d;
      in_ready_q <= in_ready_d;
      addr_q     <= addr_d;
      instr_q    <= instr_d;
      count_q    <= count_d;
      err_q      <= err_d;
      code_q     <= code_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = (state_q == ST_OUT);
  assign bus.out_addr  = addr_q;
  assign bus.out_instr = instr_q;
  assign err           = err_q;
  assign err_code      = code_q;
  assign count         = count_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder with a behavioural encoding model.
module tb_instr_encoder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [31:0] base_addr;
  logic        err;
  logic [2:0]  err_code;
  logic [15:0] count;

  instr_encoder_if bus();

  instr_encoder dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .base_addr (base_addr),
    .bus       (bus),
    .err       (err),
    .err_code  (err_code),
    .count     (count)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  bit [31:0]   exp_addr;
  int unsigned exp_count;
  bit          exp_err;
  int unsigned exp_code;

  // Reference encoding built from field arithmetic; code 0 means legal.
  function automatic void ref_encode(input int unsigned kind, rd, rs1, rs2, f3, alt,
                                     input bit [31:0] imm, output bit [31:0] w,
                                     output int unsigned code);
    int si;
    si = int'(imm);
    w = 0;
    code = 0;
    case (kind)
      0: begin
        w = (alt << 30) | (rs2 << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | 32'h33;
        if (alt == 1 && f3 != 0) code = 3;
      end
      1: begin
        w = ((imm & 32'hFFF) << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | 32'h13;
        if (si < -2048 || si > 2047) code = 1;
        else if (f3 == 1 && ((imm >> 5) & 32'h7F) != 0) code = 3;
      end
      2: begin
        w = ((imm & 32'hFFF) << 20) | (rs1 << 15) | (2 << 12) | (rd << 7) | 32'h03;
        if (si < -2048 || si > 2047) code = 1;
      end
      3: begin
        w = (((imm >> 5) & 32'h7F) << 25) | (rs2 << 20) | (rs1 << 15) | (2 << 12) |
            ((imm & 32'h1F) << 7) | 32'h23;
        if (si < -2048 || si > 2047) code = 1;
      end
      4: begin
        w = (((imm >> 12) & 1) << 31) | (((imm >> 5) & 32'h3F) << 25) | (rs2 << 20) |
            (rs1 << 15) | (((imm >> 1) & 32'hF) << 8) | (((imm >> 11) & 1) << 7) | 32'h63;
        if (si < -4096 || si > 4095) code = 1;
        else if ((imm & 1) != 0) code = 2;
      end
      5: begin
        w = (((imm >> 20) & 1) << 31) | (((imm >> 1) & 32'h3FF) << 21) |
            (((imm >> 11) & 1) << 20) | (((imm >> 12) & 32'hFF) << 12) | (rd << 7) | 32'h6F;
        if (si < -1048576 || si > 1048575) code = 1;
        else if ((imm & 1) != 0) code = 2;
      end
      6: begin
        w = (imm & 32'hFFFFF000) | (rd << 7) | 32'h37;
        if ((imm & 32'hFFF) != 0) code = 3;
      end
      default: code = 3;
    endcase
  endfunction

  function automatic bit [31:0] rand_imm();
    int v;
    case ($urandom_range(0, 5))
      0: v = int'($urandom_range(0, 4095)) - 2048;
      1: v = int'($urandom_range(0, 8191)) - 4096;
      2: v = int'($urandom_range(0, 2097151)) - 1048576;
      3: v = int'($urandom);
      4: v = int'($urandom & 32'hFFFFF000);
      default: v = int'($urandom_range(0, 31));
    endcase
    return bit'(1) ? v : 0;
  endfunction

  task automatic drive_req(input int unsigned kind, rd, rs1, rs2, f3, alt, input bit [31:0] imm);
    bus.in_kind   = 3'(kind);
    bus.in_rd     = 5'(rd);
    bus.in_rs1    = 5'(rs1);
    bus.in_rs2    = 5'(rs2);
    bus.in_funct3 = 3'(f3);
    bus.in_alt    = 1'(alt);
    bus.in_imm    = imm;
    bus.in_valid  = 1'b1;
  endtask

  task automatic do_start(input bit [31:0] base);
    start = 1'b1;
    base_addr = base;
    @(posedge clk); #1;
    start = 1'b0;
    exp_addr = base;
    exp_count = 0;
    exp_err = 0;
    exp_code = 0;
  endtask

  // One full request with out_ready high; checks the word (if legal) and the status afterwards.
  task automatic do_req(input int unsigned kind, rd, rs1, rs2, f3, alt, input bit [31:0] imm,
                        output bit [31:0] obs_w, output bit [31:0] obs_a);
    bit [31:0] ew;
    int unsigned ec;
    int unsigned n;
    ref_encode(kind, rd, rs1, rs2, f3, alt, imm, ew, ec);
    n = 0;
    while (bus.in_ready !== 1'b1 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++; $display("FAIL req_ready_timeout: in_ready=%b expected 1", bus.in_ready);
    end
    drive_req(kind, rd, rs1, rs2, f3, alt, imm);
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    checks++;
    if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b0) begin
      errors++; $display("FAIL enc_cycle: in_ready=%b out_valid=%b expected 0 0", bus.in_ready, bus.out_valid);
    end
    @(posedge clk); #1;
    obs_w = bus.out_instr;
    obs_a = bus.out_addr;
    if (ec == 0) begin
      checks++;
      if (bus.out_valid !== 1'b1) begin
        errors++; $display("FAIL out_valid_latency: got %b expected 1 (kind %0d imm %h)", bus.out_valid, kind, imm);
      end
      checks++;
      if (bus.out_instr !== ew) begin
        errors++; $display("FAIL out_instr: got %h expected %h (kind %0d imm %h)", bus.out_instr, ew, kind, imm);
      end
      checks++;
      if (bus.out_addr !== exp_addr) begin
        errors++; $display("FAIL out_addr: got %h expected %h", bus.out_addr, exp_addr);
      end
      @(posedge clk); #1;
      exp_addr = exp_addr + 4;
      if (exp_count != 16'hFFFF) exp_count++;
    end else begin
      if (!exp_err) exp_code = ec;
      exp_err = 1;
    end
    checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      errors++; $display("FAIL back_to_idle: out_valid=%b in_ready=%b expected 0 1", bus.out_valid, bus.in_ready);
    end
    checks++;
    if (bus.out_addr !== exp_addr || count !== exp_count[15:0]) begin
      errors++; $display("FAIL addr_count: addr=%h count=%0d expected %h %0d", bus.out_addr, count, exp_addr, exp_count);
    end
    checks++;
    if (err !== exp_err || err_code !== exp_code[2:0]) begin
      errors++; $display("FAIL err_status: err=%b code=%0d expected %b %0d", err, err_code, exp_err, exp_code);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #3;
    checks++;
    if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b0 || bus.out_addr !== 32'h0 ||
        bus.out_instr !== 32'h0 || count !== 16'h0 || err !== 1'b0 || err_code !== 3'h0) begin
      errors++; $display("FAIL reset_values: rdy=%b ov=%b addr=%h instr=%h cnt=%h err=%b code=%h expected all 0",
                         bus.in_ready, bus.out_valid, bus.out_addr, bus.out_instr, count, err, err_code);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      errors++; $display("FAIL reset_release: in_ready=%b out_valid=%b expected 1 0", bus.in_ready, bus.out_valid);
    end
    exp_addr = 0; exp_count = 0; exp_err = 0; exp_code = 0;
  endtask

  task automatic test_start();
    do_start(32'h100);
    checks++;
    if (bus.out_addr !== 32'h100 || count !== 16'h0 || bus.in_ready !== 1'b1) begin
      errors++; $display("FAIL start_load: addr=%h count=%0d in_ready=%b expected 100 0 1", bus.out_addr, count, bus.in_ready);
    end
    // start and in_valid together: request must be ignored
    drive_req(0, 3, 1, 2, 0, 0, 0);
    start = 1'b1;
    base_addr = 32'h100;
    @(posedge clk); #1;
    start = 1'b0;
    bus.in_valid = 1'b0;
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++; $display("FAIL start_vs_valid: in_ready=%b expected 1", bus.in_ready);
    end
    @(posedge clk); #1;
    checks++;
    if (bus.out_valid !== 1'b0 || count !== 16'h0) begin
      errors++; $display("FAIL start_vs_valid_drop: out_valid=%b count=%0d expected 0 0", bus.out_valid, count);
    end
  endtask

  task automatic test_r_type();
    bit [31:0] w, a;
    do_start(32'h100);
    do_req(0, 3, 1, 2, 0, 0, 32'h0, w, a);
    checks++;
    if (w !== 32'h002081B3 || a !== 32'h100) begin
      errors++; $display("FAIL r_add: word=%h addr=%h expected 002081b3 00000100", w, a);
    end
    do_req(0, 3, 1, 2, 0, 1, 32'h0, w, a);
    checks++;
    if (w !== 32'h402081B3 || a !== 32'h104) begin
      errors++; $display("FAIL r_sub: word=%h addr=%h expected 402081b3 00000104", w, a);
    end
    checks++;
    if (count !== 16'd2) begin
      errors++; $display("FAIL r_count: got %0d expected 2", count);
    end
  endtask

  task automatic test_formats();
    bit [31:0] w, a;
    do_req(2, 5, 2, 0, 7, 0, 32'd8, w, a);
    checks++;
    if (w !== 32'h00812283) begin
      errors++; $display("FAIL lw_word: got %h expected 00812283", w);
    end
    do_req(6, 6, 0, 0, 0, 0, 32'h12345000, w, a);
    checks++;
    if (w !== 32'h12345337) begin
      errors++; $display("FAIL lui_word: got %h expected 12345337", w);
    end
    do_req(5, 1, 0, 0, 0, 0, 32'd8, w, a);
    checks++;
    if (w !== 32'h008000EF) begin
      errors++; $display("FAIL jal_word: got %h expected 008000ef", w);
    end
  endtask

  task automatic test_branch_err();
    bit [31:0] w, a;
    do_start(32'h400);
    do_req(4, 0, 1, 2, 0, 0, 32'hFFFFFFFC, w, a);
    checks++;
    if (w !== 32'hFE208EE3) begin
      errors++; $display("FAIL beq_word: got %h expected fe208ee3", w);
    end
    do_req(4, 0, 1, 2, 0, 0, 32'd3, w, a);
    checks++;
    if (err !== 1'b1 || err_code !== 3'd2 || count !== 16'd1 || bus.out_addr !== 32'h404) begin
      errors++; $display("FAIL beq_misalign: err=%b code=%0d count=%0d addr=%h expected 1 2 1 404", err, err_code, count, bus.out_addr);
    end
    do_req(4, 0, 1, 2, 0, 0, 32'd4096, w, a);
    checks++;
    if (err !== 1'b1 || err_code !== 3'd2 || count !== 16'd1) begin
      errors++; $display("FAIL beq_range_sticky: err=%b code=%0d count=%0d expected 1 2 1", err, err_code, count);
    end
  endtask

  task automatic test_backpressure();
    bit [31:0] ew, a0;
    int unsigned ec;
    do_start(32'h200);
    ref_encode(1, 7, 9, 0, 0, 0, 32'h7FF, ew, ec);
    drive_req(1, 7, 9, 0, 0, 0, 32'h7FF);
    bus.out_ready = 1'b0;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    @(posedge clk); #1;
    a0 = bus.out_addr;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (bus.out_valid !== 1'b1 || bus.out_addr !== 32'h200 || bus.out_instr !== ew || bus.in_ready !== 1'b0) begin
        errors++; $display("FAIL stall_cycle%0d: ov=%b addr=%h instr=%h rdy=%b expected 1 200 %h 0",
                           i, bus.out_valid, bus.out_addr, bus.out_instr, bus.in_ready, ew);
      end
      @(posedge clk); #1;
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.out_addr !== a0 + 32'd4 || count !== 16'd1) begin
      errors++; $display("FAIL stall_release: ov=%b addr=%h count=%0d expected 0 %h 1", bus.out_valid, bus.out_addr, count, a0 + 32'd4);
    end
    exp_addr = 32'h204;
    exp_count = 1;
  endtask

  task automatic test_start_in_out();
    bit [31:0] w, a;
    do_start(32'h500);
    do_req(7, 0, 0, 0, 0, 0, 32'h0, w, a);
    drive_req(6, 2, 0, 0, 0, 0, 32'hABCDE000);
    bus.out_ready = 1'b0;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (bus.out_valid !== 1'b1 || err !== 1'b1) begin
      errors++; $display("FAIL pre_start_out: out_valid=%b err=%b expected 1 1", bus.out_valid, err);
    end
    do_start(32'h3000);
    checks++;
    if (bus.out_valid !== 1'b0 || bus.out_addr !== 32'h3000 || count !== 16'h0 || err !== 1'b0 || err_code !== 3'h0) begin
      errors++; $display("FAIL start_in_out: ov=%b addr=%h count=%0d err=%b code=%0d expected 0 3000 0 0 0",
                         bus.out_valid, bus.out_addr, count, err, err_code);
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (bus.out_addr !== 32'h3000 || count !== 16'h0) begin
      errors++; $display("FAIL start_discard: addr=%h count=%0d expected 3000 0", bus.out_addr, count);
    end
  endtask

  task automatic test_wrap();
    bit [31:0] w, a;
    do_start(32'hFFFFFFFC);
    do_req(6, 4, 0, 0, 0, 0, 32'h00001000, w, a);
    checks++;
    if (a !== 32'hFFFFFFFC || bus.out_addr !== 32'h0) begin
      errors++; $display("FAIL addr_wrap: write_addr=%h next=%h expected fffffffc 00000000", a, bus.out_addr);
    end
  endtask

  task automatic test_reset_mid_enc();
    do_start(32'h40);
    drive_req(2, 1, 1, 0, 0, 0, 32'd4);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b0 || bus.out_addr !== 32'h0 ||
        bus.out_instr !== 32'h0 || count !== 16'h0 || err !== 1'b0 || err_code !== 3'h0) begin
      errors++; $display("FAIL reset_mid_enc: rdy=%b ov=%b addr=%h instr=%h cnt=%h err=%b code=%h expected all 0",
                         bus.in_ready, bus.out_valid, bus.out_addr, bus.out_instr, count, err, err_code);
    end
    #2;
    rst_n = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || count !== 16'h0) begin
      errors++; $display("FAIL reset_mid_enc_after: ov=%b rdy=%b count=%0d expected 0 1 0", bus.out_valid, bus.in_ready, count);
    end
    exp_addr = 0; exp_count = 0; exp_err = 0; exp_code = 0;
  endtask

  task automatic test_random();
    bit [31:0] w, a;
    do_start($urandom);
    for (int i = 0; i < 120; i++) begin
      do_req($urandom_range(0, 7), $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31),
             $urandom_range(0, 7), $urandom_range(0, 1), rand_imm(), w, a);
      if ($urandom_range(0, 29) == 0) do_start($urandom);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    base_addr = '0;
    bus.in_valid = 1'b0;
    bus.in_kind = '0;
    bus.in_rd = '0;
    bus.in_rs1 = '0;
    bus.in_rs2 = '0;
    bus.in_funct3 = '0;
    bus.in_alt = 1'b0;
    bus.in_imm = '0;
    bus.out_ready = 1'b1;
    test_reset();
    test_start();
    test_r_type();
    test_formats();
    test_branch_err();
    test_backpressure();
    test_start_in_out();
    test_wrap();
    test_reset_mid_enc();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
